// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// group carries registered between stages, valid/ready flow control with a global stall.
module cla_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = (GROUP >= 1) ? WIDTH / GROUP : 1;

  if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("cla_pipe: WIDTH must be a positive multiple of GROUP");
  end

  // Every carry is a flat sum of products of g/p and the group carry-in (no ripple).
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] p,
                                               input logic [GROUP-1:0] g,
                                               input logic             c0);
    logic [GROUP:0] c;
    logic           term;
    logic           prod;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = term | (prod & c0);
    end
    return c;
  endfunction

  logic en;

  logic [WIDTH-1:0] a_in [NG];
  logic [WIDTH-1:0] b_in [NG];
  logic [WIDTH-1:0] s_in [NG];
  logic [WIDTH-1:0] s_nx [NG];
  logic             c_in [NG];
  logic             v_in [NG];

  logic [WIDTH-1:0] a_p  [NG];
  logic [WIDTH-1:0] b_p  [NG];
  logic [WIDTH-1:0] s_p  [NG];
  logic             c_p  [NG];
  logic             cm_p [NG];
  logic             vld_p[NG];

  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NG; k++) begin : stg
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    if (k == 0) begin : g_head
      assign a_in[k] = A;
      assign b_in[k] = B ^ {WIDTH{sub}};
      assign s_in[k] = '0;
      assign c_in[k] = sub | cin;
      assign v_in[k] = in_valid;
    end else begin : g_link
      assign a_in[k] = a_p[k-1];
      assign b_in[k] = b_p[k-1];
      assign s_in[k] = s_p[k-1];
      assign c_in[k] = c_p[k-1];
      assign v_in[k] = vld_p[k-1];
    end

    assign p = a_in[k][k*GROUP +: GROUP] ^ b_in[k][k*GROUP +: GROUP];
    assign g = a_in[k][k*GROUP +: GROUP] & b_in[k][k*GROUP +: GROUP];
    assign c = lookahead(p, g, c_in[k]);
    // Bits above this group are still zero in s_in, so OR-ing in the new group is exact.
    assign s_nx[k] = s_in[k] | (WIDTH'(p ^ c[GROUP-1:0]) << (k * GROUP));

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p[k] <= 1'b0;
      end else if (en) begin
        vld_p[k] <= v_in[k];
      end
    end

    // ---- stage k register boundary ----
    if (k == NG - 1) begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          s_p[k]  <= '0;
          c_p[k]  <= 1'b0;
          cm_p[k] <= 1'b0;
        end else if (en) begin
          s_p[k]  <= s_nx[k];
          c_p[k]  <= c[GROUP];
          cm_p[k] <= c[GROUP-1];
        end
      end
      always_ff @(posedge clk) begin
        if (en) begin
          a_p[k] <= a_in[k];
          b_p[k] <= b_in[k];
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (en) begin
          a_p[k]  <= a_in[k];
          b_p[k]  <= b_in[k];
          s_p[k]  <= s_nx[k];
          c_p[k]  <= c[GROUP];
          cm_p[k] <= c[GROUP-1];
        end
      end
    end
  end

  assign out_valid = vld_p[NG-1];
  assign S         = s_p[NG-1];
  assign cout      = c_p[NG-1];
  assign ovf       = c_p[NG-1] ^ cm_p[NG-1];

endmodule
